// File: rtl/reg_status_table_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_status_table_mp
// Description : Multi-ported register status table holding one {valid, tag}
//               entry per architectural register for ROB-based renaming.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_status_table_mp #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int TAG_W    = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_CMT  = 2,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD*TAG_W-1:0]   rd_tag,
    output logic [NUM_RD-1:0]         rd_valid,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [TAG_W-1:0]          wr_tag,
    input  logic [NUM_CMT-1:0]        cmt_valid,
    input  logic [NUM_CMT*TAG_W-1:0]  cmt_tag,
    input  logic                      flush,
    output logic [NUM_REGS-1:0]       busy_vec,
    output logic [CNT_W-1:0]          busy_cnt
);

    localparam bit c_ADDR_FULL = (NUM_REGS >= (1 << ADDR_W));
    localparam bit c_ZERO_REG  = (ZERO_REG != 0);

    logic [NUM_REGS-1:0]             r_valid;
    logic [NUM_REGS-1:0][TAG_W-1:0]  r_tag;

    logic [NUM_REGS-1:0] w_cmt_hit;
    logic                w_wr_range;
    logic                w_wr_ok;
    logic [NUM_RD-1:0]   w_rd_range;
    logic [CNT_W-1:0]    w_cnt;

    // Address range checks only exist when the address space exceeds the table.
    generate
        if (c_ADDR_FULL) begin : g_range_full
            assign w_wr_range = 1'b1;
            assign w_rd_range = '1;
        end else begin : g_range_part
            localparam logic [ADDR_W:0] c_NREG = (ADDR_W+1)'(NUM_REGS);
            assign w_wr_range = ({1'b0, wr_addr} < c_NREG);
            for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_range
                assign w_rd_range[p] = ({1'b0, rd_addr[p*ADDR_W +: ADDR_W]} < c_NREG);
            end
        end
    endgenerate

    assign w_wr_ok = wr_en & w_wr_range & ~(c_ZERO_REG && (wr_addr == '0));

    // An entry retires when any commit port carries its current tag.
    always_comb begin
        w_cmt_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            for (int c = 0; c < NUM_CMT; c++) begin
                if (cmt_valid[c] && (cmt_tag[c*TAG_W +: TAG_W] == r_tag[i])) begin
                    w_cmt_hit[i] = r_valid[i];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_tag   <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (flush) begin
                    r_valid[i] <= 1'b0;
                end else if (w_wr_ok && (wr_addr == ADDR_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_tag[i]   <= wr_tag;
                end else if (w_cmt_hit[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [ADDR_W-1:0] w_a;
            logic              w_ok;
            assign w_a  = rd_addr[p*ADDR_W +: ADDR_W];
            assign w_ok = w_rd_range[p] & ~(c_ZERO_REG && (w_a == '0));
            assign rd_valid[p]              = w_ok & r_valid[w_a] & ~w_cmt_hit[w_a];
            assign rd_tag[p*TAG_W +: TAG_W] = w_ok ? r_tag[w_a] : '0;
        end
    endgenerate

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt = w_cnt + CNT_W'(r_valid[i]);
        end
    end

    assign busy_vec = r_valid;
    assign busy_cnt = w_cnt;

endmodule
`default_nettype wire
